// File: rtl/multicycle_controller_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | multicycle_controller_pkg: states, datapath select codes, opcodes     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package multicycle_controller_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    EXECUTEU = 4'd8,
    ALUWB    = 4'd9,
    BRANCH   = 4'd10,
    JAL      = 4'd11,
    JALR     = 4'd12
  } state_t;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_SUBU  = 2'b11;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  function automatic logic [2:0] imm_sel(input logic [6:0] op);
    case (op)
      OP_STORE:         return IMM_S;
      OP_BRANCH:        return IMM_B;
      OP_JAL:           return IMM_J;
      OP_LUI, OP_AUIPC: return IMM_U;
      default:          return IMM_I;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/multicycle_controller_branch_resolver.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | branch_resolver: branch-taken decision from funct3 and ALU flags      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module branch_resolver (
  input  logic [2:0] Funct3,
  input  logic       Zero,
  input  logic       Negative,
  input  logic       Overflow,
  input  logic       Carry,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    case (Funct3)
      3'b000:  taken = Zero;
      3'b001:  taken = !Zero;
      3'b100:  taken = Negative ^ Overflow;
      3'b101:  taken = !(Negative ^ Overflow);
      3'b110:  taken = !Carry;
      3'b111:  taken = Carry;
      default: taken = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | multicycle_controller: main control FSM of the multicycle RV32I core  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter state_t RESET_STATE = FETCH
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] Op,
  input  logic [2:0] Funct3,
  input  logic       Zero,
  input  logic       Negative,
  input  logic       Overflow,
  input  logic       Carry,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [2:0] ImmSrc,
  output logic       Illegal,
  output logic [3:0] State
);

  state_t state_q, state_d;
  state_t w_dec_next;
  logic   w_dec_illegal;
  logic   w_taken;

  branch_resolver u_branch_resolver (
    .Funct3   (Funct3),
    .Zero     (Zero),
    .Negative (Negative),
    .Overflow (Overflow),
    .Carry    (Carry),
    .taken    (w_taken)
  );

  // Decode target; unsupported encodings retire as a NOP back in FETCH.
  always_comb begin
    w_dec_next    = FETCH;
    w_dec_illegal = 1'b0;
    case (Op)
      OP_LOAD, OP_STORE: w_dec_next = MEMADR;
      OP_REG:            w_dec_next = EXECUTER;
      OP_IMM:            w_dec_next = EXECUTEI;
      OP_BRANCH: begin
        if (Funct3[2:1] == 2'b01) w_dec_illegal = 1'b1;
        else                      w_dec_next    = BRANCH;
      end
      OP_JAL:            w_dec_next = JAL;
      OP_JALR:           w_dec_next = JALR;
      OP_LUI, OP_AUIPC:  w_dec_next = EXECUTEU;
      default:           w_dec_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= RESET_STATE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:    if (MemReady) state_d = DECODE;
      DECODE:   state_d = w_dec_next;
      MEMADR:   state_d = Op[5] ? MEMWRITE : MEMREAD;
      MEMREAD:  if (MemReady) state_d = MEMWB;
      MEMWB:    state_d = FETCH;
      MEMWRITE: if (MemReady) state_d = FETCH;
      EXECUTER, EXECUTEI, EXECUTEU: state_d = ALUWB;
      ALUWB:    state_d = FETCH;
      BRANCH:   state_d = FETCH;
      JALR:     state_d = JAL;
      JAL:      state_d = ALUWB;
      default:  state_d = FETCH;
    endcase
  end

  always_comb begin
    PCWrite   = 1'b0;
    AdrSrc    = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    RegWrite  = 1'b0;
    ResultSrc = RES_ALUOUT;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_RD2;
    ALUOp     = ALUOP_ADD;
    Illegal   = 1'b0;
    ImmSrc    = imm_sel(Op);
    State     = state_q;
    case (state_q)
      FETCH: begin
        MemRead = 1'b1;
        if (MemReady) begin
          IRWrite   = 1'b1;
          PCWrite   = 1'b1;
          ALUSrcB   = SRCB_FOUR;
          ResultSrc = RES_ALURESULT;
        end
      end
      DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        Illegal = w_dec_illegal;
      end
      MEMADR, JALR: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_IMM;
      end
      MEMREAD: begin
        AdrSrc  = 1'b1;
        MemRead = 1'b1;
      end
      MEMWB: begin
        ResultSrc = RES_DATA;
        RegWrite  = 1'b1;
      end
      MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      EXECUTER: begin
        ALUSrcA = SRCA_RD1;
        ALUOp   = ALUOP_FUNCT;
      end
      EXECUTEI: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_IMM;
        ALUOp   = ALUOP_FUNCT;
      end
      EXECUTEU: begin
        ALUSrcA = (Op == OP_LUI) ? SRCA_ZERO : SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
      end
      ALUWB: RegWrite = 1'b1;
      BRANCH: begin
        ALUSrcA = SRCA_RD1;
        ALUOp   = (Funct3[2:1] == 2'b11) ? ALUOP_SUBU : ALUOP_SUB;
        PCWrite = w_taken;
      end
      JAL: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_FOUR;
        PCWrite = 1'b1;
      end
      default: ;
    endcase
    // Reset cycle drives every output low so no strobe can escape an aborted step.
    if (reset) begin
      PCWrite   = 1'b0;
      AdrSrc    = 1'b0;
      MemRead   = 1'b0;
      MemWrite  = 1'b0;
      IRWrite   = 1'b0;
      RegWrite  = 1'b0;
      ResultSrc = 2'b00;
      ALUSrcA   = 2'b00;
      ALUSrcB   = 2'b00;
      ALUOp     = 2'b00;
      ImmSrc    = 3'b000;
      Illegal   = 1'b0;
      State     = 4'd0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_multicycle_controller: scoreboard bench for the control FSM        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_multicycle_controller;
  import multicycle_controller_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] Op = 7'd0;
  logic [2:0] Funct3 = 3'd0;
  logic       Zero = 1'b0, Negative = 1'b0, Overflow = 1'b0, Carry = 1'b0;
  logic       MemReady = 1'b0;
  logic       PCWrite, AdrSrc, MemRead, MemWrite, IRWrite, RegWrite, Illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
  logic [2:0] ImmSrc;
  logic [3:0] State;

  typedef struct packed {
    logic       pc_write, adr_src, mem_read, mem_write, ir_write, reg_write;
    logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
    logic [2:0] imm_src;
    logic       illegal;
    logic [3:0] state;
  } outs_t;

  typedef struct {
    logic  rst;
    logic  mem_ready;
    outs_t exp;
  } step_t;

  step_t sb[$];
  outs_t act;
  int    ntests = 0;
  int    nfail  = 0;

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct3(Funct3),
    .Zero(Zero), .Negative(Negative), .Overflow(Overflow), .Carry(Carry),
    .MemReady(MemReady), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ImmSrc(ImmSrc), .Illegal(Illegal),
    .State(State)
  );

  assign act = {PCWrite, AdrSrc, MemRead, MemWrite, IRWrite, RegWrite,
                ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, Illegal, State};

  function automatic logic [2:0] imm_model(input logic [6:0] op);
    case (op)
      7'b0000011, 7'b0010011, 7'b1100111: return 3'b000;
      7'b0100011:                         return 3'b001;
      7'b1100011:                         return 3'b010;
      7'b1101111:                         return 3'b011;
      7'b0110111, 7'b0010111:             return 3'b100;
      default:                            return 3'b000;
    endcase
  endfunction

  function automatic outs_t base(input logic [3:0] st);
    outs_t o = '0;
    o.state   = st;
    o.imm_src = imm_model(Op);
    return o;
  endfunction

  task automatic push(input logic rst, input logic mr, input outs_t o);
    step_t s;
    s.rst = rst; s.mem_ready = mr; s.exp = o;
    sb.push_back(s);
  endtask

  task automatic push_fetch(input logic mr);
    outs_t o = base(FETCH);
    o.mem_read = 1'b1;
    if (mr) begin
      o.ir_write = 1'b1; o.pc_write = 1'b1;
      o.alu_src_b = 2'b10; o.result_src = 2'b10;
    end
    push(1'b0, mr, o);
  endtask

  task automatic push_decode(input logic ill, input logic mr);
    outs_t o = base(DECODE);
    o.alu_src_a = 2'b01; o.alu_src_b = 2'b01; o.illegal = ill;
    push(1'b0, mr, o);
  endtask

  task automatic push_aluwb(input logic mr);
    outs_t o = base(ALUWB);
    o.reg_write = 1'b1;
    push(1'b0, mr, o);
  endtask

  task automatic push_memadr();
    outs_t o = base(MEMADR);
    o.alu_src_a = 2'b10; o.alu_src_b = 2'b01;
    push(1'b0, 1'b1, o);
  endtask

  // Drains the scoreboard one clock per entry, comparing mid-cycle.
  task automatic run_sb(input string name);
    step_t s;
    int    idx = 0;
    while (sb.size() > 0) begin
      s = sb.pop_front();
      reset    = s.rst;
      MemReady = s.mem_ready;
      #2;
      ntests++;
      if (act !== s.exp) begin
        nfail++;
        $display("FAIL %s step %0d: got %h expected %h", name, idx, act, s.exp);
      end
      @(posedge clk);
      #1;
      idx++;
    end
  endtask

  task automatic test_reset();
    outs_t o;
    Op = 7'b0000011; Funct3 = 3'b010;
    push(1'b1, 1'b1, '0);
    push_fetch(1'b1);
    push_decode(1'b0, 1'b1);
    push_memadr();
    o = base(MEMREAD); o.adr_src = 1'b1; o.mem_read = 1'b1;
    push(1'b0, 1'b0, o);
    push(1'b1, 1'b0, '0);
    push_fetch(1'b0);
    run_sb("reset");
  endtask

  task automatic test_rtype();
    outs_t o;
    Op = 7'b0110011; Funct3 = 3'b000;
    push_fetch(1'b1);
    push_decode(1'b0, 1'b1);
    o = base(EXECUTER); o.alu_src_a = 2'b10; o.alu_op = 2'b10;
    push(1'b0, 1'b1, o);
    push_aluwb(1'b1);
    run_sb("add");
  endtask

  task automatic test_load_wait();
    outs_t o;
    Op = 7'b0000011; Funct3 = 3'b010;
    push_fetch(1'b0);
    push_fetch(1'b1);
    push_decode(1'b0, 1'b1);
    push_memadr();
    o = base(MEMREAD); o.adr_src = 1'b1; o.mem_read = 1'b1;
    push(1'b0, 1'b0, o);
    push(1'b0, 1'b0, o);
    push(1'b0, 1'b1, o);
    o = base(MEMWB); o.result_src = 2'b01; o.reg_write = 1'b1;
    push(1'b0, 1'b1, o);
    run_sb("lw");
  endtask

  task automatic test_store();
    outs_t o;
    Op = 7'b0100011; Funct3 = 3'b010;
    push_fetch(1'b1);
    push_decode(1'b0, 1'b1);
    push_memadr();
    o = base(MEMWRITE); o.adr_src = 1'b1; o.mem_write = 1'b1;
    push(1'b0, 1'b0, o);
    push(1'b0, 1'b1, o);
    run_sb("sw");
  endtask

  task automatic test_branch(input logic [2:0] f3, input logic z, input logic n,
                             input logic v, input logic c, input logic exp_taken,
                             input logic [1:0] exp_op, input string name);
    outs_t o;
    Op = 7'b1100011; Funct3 = f3;
    Zero = z; Negative = n; Overflow = v; Carry = c;
    push_fetch(1'b1);
    push_decode(1'b0, 1'b1);
    o = base(BRANCH); o.alu_src_a = 2'b10; o.alu_op = exp_op; o.pc_write = exp_taken;
    push(1'b0, 1'b1, o);
    run_sb(name);
    Zero = 1'b0; Negative = 1'b0; Overflow = 1'b0; Carry = 1'b0;
  endtask

  task automatic test_jumps();
    outs_t o;
    Op = 7'b1100111; Funct3 = 3'b000;
    push_fetch(1'b1);
    push_decode(1'b0, 1'b1);
    o = base(JALR); o.alu_src_a = 2'b10; o.alu_src_b = 2'b01;
    push(1'b0, 1'b1, o);
    o = base(JAL); o.alu_src_a = 2'b01; o.alu_src_b = 2'b10; o.pc_write = 1'b1;
    push(1'b0, 1'b1, o);
    push_aluwb(1'b1);
    run_sb("jalr");
    Op = 7'b1101111;
    push_fetch(1'b1);
    push_decode(1'b0, 1'b1);
    o = base(JAL); o.alu_src_a = 2'b01; o.alu_src_b = 2'b10; o.pc_write = 1'b1;
    push(1'b0, 1'b1, o);
    push_aluwb(1'b1);
    run_sb("jal");
  endtask

  task automatic test_upper();
    outs_t o;
    Op = 7'b0110111;
    push_fetch(1'b1);
    push_decode(1'b0, 1'b1);
    o = base(EXECUTEU); o.alu_src_a = 2'b11; o.alu_src_b = 2'b01;
    push(1'b0, 1'b1, o);
    push_aluwb(1'b1);
    run_sb("lui");
    Op = 7'b0010111;
    push_fetch(1'b1);
    push_decode(1'b0, 1'b1);
    o = base(EXECUTEU); o.alu_src_a = 2'b01; o.alu_src_b = 2'b01;
    push(1'b0, 1'b1, o);
    push_aluwb(1'b1);
    run_sb("auipc");
  endtask

  task automatic test_illegal();
    Op = 7'b0001111; Funct3 = 3'b000;
    push_fetch(1'b1);
    push_decode(1'b1, 1'b1);
    push_fetch(1'b0);
    run_sb("illegal_op");
    Op = 7'b1100011; Funct3 = 3'b010;
    push_fetch(1'b1);
    push_decode(1'b1, 1'b1);
    push_fetch(1'b0);
    run_sb("illegal_funct3");
  endtask

  // MemReady toggling in request-free states must not disturb the sequence.
  task automatic test_back_to_back();
    outs_t o;
    Op = 7'b0010011; Funct3 = 3'b000;
    push_fetch(1'b1);
    push_decode(1'b0, 1'b0);
    o = base(EXECUTEI); o.alu_src_a = 2'b10; o.alu_src_b = 2'b01; o.alu_op = 2'b10;
    push(1'b0, 1'b0, o);
    push_aluwb(1'b0);
    run_sb("addi");
    Op = 7'b0110011; Funct3 = 3'b111;
    push_fetch(1'b1);
    push_decode(1'b0, 1'b0);
    o = base(EXECUTER); o.alu_src_a = 2'b10; o.alu_op = 2'b10;
    push(1'b0, 1'b1, o);
    push_aluwb(1'b0);
    push_fetch(1'b0);
    run_sb("b2b_and");
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_load_wait();
    test_store();
    test_branch(3'b110, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11, "bltu_taken");
    test_branch(3'b101, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, "bge_not_taken");
    test_branch(3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, "beq_taken");
    test_branch(3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, "bne_not_taken");
    test_branch(3'b100, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b01, "blt_not_taken");
    test_branch(3'b111, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b11, "bgeu_taken");
    test_jumps();
    test_upper();
    test_illegal();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
`default_nettype wire
